// File: rtl/prog_seq_pkg.sv
// Shared types and default constants for the program sequencer.
package prog_seq_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned LEN_W = 4;

    localparam int unsigned      NUM_PROGS_DEF = 3;
    localparam int unsigned      START_LEN_DEF = 1;
    localparam logic [CNT_W-1:0] TIMEOUT_DEF   = 16'd1000;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        RUN,
        REPORT,
        DONE
    } state_e;

endpackage

// File: rtl/cycle_counter.sv
// Per-program cycle counter with synchronous clear, enable and a registered
// terminal-count flag that always tracks the current count.
module cycle_counter
    import prog_seq_pkg::*;
#(
    parameter logic [CNT_W-1:0] TERMINAL = 16'd999
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tc_q;

    // Saturate at all-ones so the count can never wrap.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            tc_q    <= (TERMINAL == '0);
        end else begin
            count_q <= count_d;
            tc_q    <= (count_d == TERMINAL);
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;

endmodule

// File: rtl/prog_sequencer.sv
// Launches programs 0..NUM_PROGS-1 on a processor, times each one from arm to
// done-ack, reports the count per program and aborts the run on timeout.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned      NUM_PROGS = NUM_PROGS_DEF,
    parameter int unsigned      START_LEN = START_LEN_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             DutAck,
    output logic             DutStart,
    output logic [IDX_W-1:0] ProgIdx,
    output logic [CNT_W-1:0] CycleCount,
    output logic             CountValid,
    output logic             TimedOut,
    output logic             Done,
    output logic             Busy
);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PROGS - 1);
    localparam logic [LEN_W-1:0] LAUNCH_LAST = LEN_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] TERMINAL    = TIMEOUT - CNT_W'(1);

    state_e           state_q;
    logic [LEN_W-1:0] launch_cnt_q;
    logic [IDX_W-1:0] prog_idx_q;
    logic [CNT_W-1:0] cycle_count_q;
    logic             count_valid_q;
    logic             timed_out_q;
    logic             dut_start_q;
    logic             done_q;
    logic             busy_q;

    logic             cnt_en;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_tc;

    // The counter only runs while a program is armed or running; it sits at 0 otherwise.
    assign cnt_en  = (state_q == ARM) || (state_q == RUN);
    assign cnt_clr = !cnt_en;

    cycle_counter #(
        .TERMINAL (TERMINAL)
    ) u_cycle_counter (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt_val),
        .tc_o    (cnt_tc)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            launch_cnt_q  <= '0;
            prog_idx_q    <= '0;
            cycle_count_q <= '0;
            count_valid_q <= 1'b0;
            timed_out_q   <= 1'b0;
            dut_start_q   <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            count_valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (Go) begin
                        state_q      <= LAUNCH;
                        prog_idx_q   <= '0;
                        timed_out_q  <= 1'b0;
                        launch_cnt_q <= '0;
                        dut_start_q  <= 1'b1;
                        done_q       <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                LAUNCH: begin
                    if (launch_cnt_q == LAUNCH_LAST) begin
                        state_q     <= ARM;
                        dut_start_q <= 1'b0;
                    end else begin
                        launch_cnt_q <= launch_cnt_q + LEN_W'(1);
                    end
                end
                ARM, RUN: begin
                    // An Ack on the terminal cycle cancels the abort but still reports the full budget.
                    if ((state_q == RUN) && DutAck) begin
                        state_q       <= REPORT;
                        count_valid_q <= 1'b1;
                        cycle_count_q <= cnt_tc ? TIMEOUT : cnt_val;
                    end else if (cnt_tc) begin
                        state_q       <= REPORT;
                        count_valid_q <= 1'b1;
                        cycle_count_q <= TIMEOUT;
                        timed_out_q   <= 1'b1;
                    end else if ((state_q == ARM) && !DutAck) begin
                        state_q <= RUN;
                    end
                end
                REPORT: begin
                    if (timed_out_q || (prog_idx_q == LAST_IDX)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q      <= LAUNCH;
                        prog_idx_q   <= prog_idx_q + IDX_W'(1);
                        launch_cnt_q <= '0;
                        dut_start_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    dut_start_q <= 1'b0;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign DutStart   = dut_start_q;
    assign ProgIdx    = prog_idx_q;
    assign CycleCount = cycle_count_q;
    assign CountValid = count_valid_q;
    assign TimedOut   = timed_out_q;
    assign Done       = done_q;
    assign Busy       = busy_q;

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_PROGS, default 3: programs launched per run, range 1..4.
REQ-002 The block SHALL have parameter START_LEN, default 1: cycles DutStart is held high per launch, range 1..15.
REQ-003 The block SHALL have parameter TIMEOUT, default 16'd1000: maximum cycles allowed per program.
REQ-004 Port Clk: input, 1 bit; the only clock, posedge used.
REQ-005 Port Reset: input, 1 bit; reset is synchronous and active-high.
REQ-006 Port Go: input, 1 bit; request to start a run of programs 0..NUM_PROGS-1.
REQ-007 Port DutAck: input, 1 bit; done flag from the processor.
REQ-008 Port DutStart: output, 1 bit; start/init pulse to the processor.
REQ-009 Port ProgIdx: output, 2 bits; index of the program being run or last run.
REQ-010 Port CycleCount: output, 16 bits; cycle count of the last finished or timed-out program.
REQ-011 Port CountValid: output, 1 bit; one-cycle strobe marking a new CycleCount.
REQ-012 Port TimedOut: output, 1 bit; sticky abort flag.
REQ-013 Port Done: output, 1 bit; run complete, held high until the next accepted Go.
REQ-014 Port Busy: output, 1 bit; high in every state except IDLE and DONE.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH, ARM, RUN, REPORT and DONE; all outputs SHALL be registered or Moore-decoded from state.
REQ-016 In IDLE or DONE, Go=1 SHALL move the FSM to LAUNCH on the next edge, with ProgIdx<=0 and Done, TimedOut and the cycle counter cleared.
REQ-017 Go SHALL be ignored whenever Busy=1.
REQ-018 DutStart SHALL be 1 exactly while the FSM is in LAUNCH.
REQ-019 LAUNCH SHALL last exactly START_LEN cycles and then move to ARM.
REQ-020 The cycle counter SHALL be 0 on entry to ARM and SHALL increment by 1 every cycle spent in ARM or RUN.
REQ-021 ARM SHALL wait for DutAck=0, so that an Ack still high from the previous halt is masked; when DutAck=0 the FSM SHALL move to RUN.
REQ-022 In RUN, DutAck=1 SHALL latch CycleCount<=counter and move to REPORT.
REQ-023 CountValid SHALL be 1 for exactly the single cycle spent in REPORT.
REQ-024 From REPORT, if ProgIdx==NUM_PROGS-1 the FSM SHALL go to DONE; otherwise it SHALL set ProgIdx+1 and go to LAUNCH.
REQ-025 Timeout: in ARM or RUN, when counter==TIMEOUT-1 and no valid Ack is seen that cycle, the block SHALL set CycleCount<=TIMEOUT, set TimedOut<=1 and go to REPORT, then DONE; remaining programs SHALL be skipped.
REQ-026 If DutAck=1 in RUN on the same cycle the timeout is reached, the Ack SHALL win and TimedOut SHALL stay 0.
REQ-027 The counter SHALL never wrap; the timeout SHALL always be reached first.
REQ-028 Done SHALL be 1 exactly while the FSM is in DONE.
REQ-029 Go=1 held continuously SHALL start a new run on each entry to DONE, after one DONE cycle.

Reset
REQ-030 Reset=1 at a posedge SHALL force IDLE from any state, including mid-LAUNCH and mid-RUN.
REQ-031 Under reset, all outputs SHALL be 0 (DutStart, ProgIdx, CycleCount, CountValid, TimedOut, Done, Busy) and the counter SHALL be cleared.
REQ-032 Reset SHALL take priority over Go and DutAck on the same edge.

Structure
REQ-033 Package prog_seq_pkg SHALL hold the state enum typedef and the default constants for NUM_PROGS, START_LEN and TIMEOUT.
REQ-034 One sub-module, cycle_counter, SHALL hold the 16-bit counter with clear, enable and terminal-count compare.
REQ-035 Everything else in the block SHALL be in prog_sequencer.

Verification
REQ-036 Reset, then Go pulse, with DutAck rising 20 cycles after each ARM->RUN (NUM_PROGS=3) -> three CountValid strobes with CycleCount=21 each, ProgIdx 0,1,2, then Done=1 and Busy=0.
REQ-037 DutAck held 1 through LAUNCH and ARM for 5 cycles, then dropped -> no early REPORT, and CycleCount includes the ARM cycles.
REQ-038 DutAck never rises (TIMEOUT=50) -> one CountValid with CycleCount=50, TimedOut=1, Done=1, ProgIdx=0.
REQ-039 DutAck rises exactly on the timeout cycle -> TimedOut=0, CycleCount=50, and the next program is launched.
REQ-040 Reset asserted mid-RUN of program 1 -> next cycle all outputs are 0; a later Go restarts at ProgIdx=0.
REQ-041 Go pulsed during RUN -> ignored; with START_LEN=3, DutStart is high for exactly 3 cycles per launch.
